// File: rtl/nn_sc2bin_window.sv
// nn_sc2bin_window
// Converts a signed stochastic bitstream into a binary count over a fixed
// window of 2^WINDOW_LOG2 enabled samples. Windows run back-to-back. Each
// finished count is presented on COUNT_OUT with a VALID/READY handshake.
//
// Optional feature: define NN_SC2BIN_OVERRUN_EN to add the sticky OVERRUN
// output. OVERRUN flags a result that was overwritten before the consumer
// took it. Without the macro the port is absent and an overwrite is silent.

module nn_sc2bin_window #(
  parameter int WINDOW_LOG2 = 4,
  parameter int CW          = WINDOW_LOG2 + 2
) (
  input  logic                 CLK,
  input  logic                 INIT,
  input  logic                 EN,
  input  logic                 CLR,
  input  logic                 IN,
  input  logic                 SIGN_IN,
  input  logic                 READY,
  output logic signed [CW-1:0] COUNT_OUT,
  output logic                 VALID,
`ifdef NN_SC2BIN_OVERRUN_EN
  output logic                 BUSY,
  output logic                 OVERRUN
`else
  output logic                 BUSY
`endif
);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Index of the last sample of a window (all ones) and the step of the index.
  localparam logic [WINDOW_LOG2-1:0] IDX_LAST = '1;
  localparam logic [WINDOW_LOG2-1:0] IDX_ONE  = {{(WINDOW_LOG2-1){1'b0}}, 1'b1};

  // Per-sample contribution values in the accumulator's signed width.
  localparam logic signed [CW-1:0] PLUS_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic signed [CW-1:0] MINUS_ONE = '1;
  localparam logic signed [CW-1:0] ZERO      = '0;

  state_t                 state;
  logic signed [CW-1:0]   acc;
  logic [WINDOW_LOG2-1:0] idx;
  logic signed [CW-1:0]   contrib;
  logic signed [CW-1:0]   acc_next;
  logic                   take_sample;
  logic                   last_sample;

  // Decode this cycle's sample into +1 / -1 / 0 and find the window boundary.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so that no path
    // leaves it unassigned and infers a latch.
    contrib = ZERO;
    if (IN) begin
      contrib = SIGN_IN ? MINUS_ONE : PLUS_ONE;
    end
    acc_next = acc + contrib;
    // CLR wins over EN: a sample in a clearing cycle is not counted. In IDLE
    // the index is already zero, so the first enabled sample is sample 0.
    take_sample = EN && !CLR;
    last_sample = take_sample && (idx == IDX_LAST);
  end

  // Window FSM, accumulator, sample index, and result/handshake registers.
  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      // NOTE: sequential state uses non-blocking assignments, so all
      // registers sample the pre-edge values and the order of the
      // statements below does not change the result.
      state     <= IDLE;
      acc       <= ZERO;
      idx       <= '0;
      COUNT_OUT <= ZERO;
      VALID     <= 1'b0;
`ifdef NN_SC2BIN_OVERRUN_EN
      OVERRUN   <= 1'b0;
`endif
    end else begin
      // The consumer takes a pending result. A result latched later in this
      // same block overrides the clear, so VALID stays high with new data.
      if (VALID && READY) begin
        VALID <= 1'b0;
      end

      if (CLR) begin
        // Drop the window in progress. The last published result and its
        // VALID flag are left alone.
        state <= IDLE;
        acc   <= ZERO;
        idx   <= '0;
`ifdef NN_SC2BIN_OVERRUN_EN
        OVERRUN <= 1'b0;
`endif
      end else if (take_sample) begin
        state <= ACCUM;
        idx   <= idx + IDX_ONE;
        if (last_sample) begin
          // Publish the window total including this last sample and start
          // the next window at once, with no dead cycle.
          COUNT_OUT <= acc_next;
          acc       <= ZERO;
          VALID     <= 1'b1;
`ifdef NN_SC2BIN_OVERRUN_EN
          if (VALID && !READY) begin
            OVERRUN <= 1'b1;
          end
`endif
        end else begin
          acc <= acc_next;
        end
      end
      // EN=0 without CLR: pause. The accumulator, index and state hold.
    end
  end

  // BUSY decodes the state register directly, so it is glitch-free.
  always_comb begin
    BUSY = (state == ACCUM);
  end

endmodule

// File: doc/nn_sc2bin_window.md
NN_SC2BIN_WINDOW -- requirements
Module: nn_sc2bin_window

Interface
REQ-001 Parameter WINDOW_LOG2, default 4: window length is 2^WINDOW_LOG2 counted samples.
REQ-002 Parameter CW, default WINDOW_LOG2+2: width of the signed two's-complement count, and the minimum legal value.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 INIT  input  1  reset, asynchronous, active-high.
REQ-005 EN  input  1  sample enable; IN/SIGN_IN are counted only in cycles where EN=1.
REQ-006 CLR  input  1  synchronous clear of the window in progress.
REQ-007 IN  input  1  stochastic bitstream from the upstream node activation output.
REQ-008 SIGN_IN  input  1  polarity of IN: 0 = positive, 1 = negative.
REQ-009 READY  input  1  consumer accepts COUNT_OUT in this cycle.
REQ-010 COUNT_OUT  output  CW  signed window result.
REQ-011 VALID  output  1  COUNT_OUT holds an unconsumed result.
REQ-012 BUSY  output  1  high while state is ACCUM.
REQ-013 OVERRUN  output  1  sticky lost-result flag; present only per REQ-030.

Function
REQ-014 States: IDLE and ACCUM; BUSY=1 exactly in ACCUM.
REQ-015 Transitions:
- IDLE->ACCUM on the first cycle with EN=1 and CLR=0; that cycle's sample is counted as sample 0.
- ACCUM->IDLE only on CLR=1.
REQ-016 Per counted sample, the contribution to the accumulator is:
- +1 when IN=1 and SIGN_IN=0;
- -1 when IN=1 and SIGN_IN=1;
- 0 when IN=0.
REQ-017 In ACCUM with EN=0, the accumulator and the sample index hold; no sample is counted (pause, no timeout).
REQ-018 The sample index shall be a WINDOW_LOG2-bit counter that wraps from 2^WINDOW_LOG2-1 to 0.
REQ-019 On the counted sample with index 2^WINDOW_LOG2-1:
- COUNT_OUT <= accumulator + contribution;
- accumulator <= 0;
- VALID <= 1;
- state remains ACCUM, so windows run back-to-back with no dead cycle.
REQ-020 Latency: COUNT_OUT and VALID update on the clock edge that ends the last sample cycle, so they are visible the cycle after the last sample.
REQ-021 The accumulator shall never overflow; result range is -2^WINDOW_LOG2 to +2^WINDOW_LOG2 inclusive.
REQ-022 Handshake: VALID clears on the edge where VALID=1 and READY=1, unless a new result is latched on that same edge, in which case VALID stays 1 with the new value.
REQ-023 A window completing while VALID=1 and READY=0 overwrites COUNT_OUT.
REQ-024 COUNT_OUT holds its value between windows and after VALID clears.
REQ-025 CLR=1 (priority over EN):
- clears the accumulator and sample index and forces IDLE;
- does not affect COUNT_OUT or VALID;
- a sample presented in the CLR cycle is discarded;
- a window completing in the CLR cycle is discarded.
REQ-026 READY is ignored while VALID=0.

Reset
REQ-027 INIT=1 asynchronously forces: state IDLE, accumulator 0, sample index 0, COUNT_OUT 0, VALID 0, BUSY 0, OVERRUN 0.
REQ-028 Reset asserted mid-window discards the partial window; after release, counting restarts per REQ-015.

Configuration
REQ-029 Macro NN_SC2BIN_OVERRUN_EN selects the overrun-flag feature.
REQ-030 Behaviour with NN_SC2BIN_OVERRUN_EN defined:
- OVERRUN port exists;
- OVERRUN is set on any edge where REQ-023 applies;
- OVERRUN is cleared only by INIT or CLR;
- a set and a CLR in the same cycle leave OVERRUN cleared.
REQ-031 Behaviour with NN_SC2BIN_OVERRUN_EN undefined: the OVERRUN port and its logic are absent, and overwrite is silent.

Verification (WINDOW_LOG2=4)
REQ-032 EN=1, READY=1, IN=1, SIGN_IN=0 for 16 cycles -> cycle 17: VALID=1, COUNT_OUT=+16; VALID=0 on the following cycle.
REQ-033 EN=1, IN=1, SIGN_IN alternating 0/1 for 16 cycles, then IN=1, SIGN_IN=1 for 16 cycles -> results 0 then -16, with no gap between windows.
REQ-034 EN=1, IN=1, SIGN_IN=0 for 8 cycles, EN=0 for 5 cycles, then 8 more enabled cycles -> a single result of +16, VALID one cycle after the 16th counted sample, BUSY=1 throughout.
REQ-035 READY=0 across two full windows of +16 then +4 -> COUNT_OUT=+4, VALID=1, OVERRUN=1 (macro defined); CLR then OVERRUN=0 with COUNT_OUT unchanged.
REQ-036 INIT pulsed after 10 samples, then 16 samples of IN=0 -> COUNT_OUT=0 and VALID=1 after exactly 16 samples; no partial count leaks into the result.
REQ-037 READY=1 on the same cycle a new window completes, with a previous result pending -> VALID stays 1 and COUNT_OUT shows the new value.
